// File: rtl/rr_dec_arbiter_pkg.sv
// Shared constants and types for the round-robin arbiter with decoded grant.
// State encodings are plain localparams so legacy code can compare against them.
package rr_dec_arbiter_pkg;

  localparam int ID_W = 3;

  typedef logic [ID_W-1:0] id_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Pointer value after reset: the search then starts at requester 0.
  localparam id_t RST_PTR = 3'd7;

endpackage

// File: rtl/rr_onehot_dec.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module rr_onehot_dec
  import rr_dec_arbiter_pkg::*;
(
  output logic [7:0] out,
  input  id_t        in,
  input  logic       en
);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for 8 requesters: hold-until-release grant, one-cycle gap, one-hot grant via decoder.
// Optional forced release after MAX_HOLD grant cycles when RR_DEC_ARBITER_TIMEOUT_EN is defined.
module rr_dec_arbiter
  import rr_dec_arbiter_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output id_t              gnt_id,
  output logic             gnt_vld,
  output logic             timeout
);

  if (N_REQ != 8) begin : g_bad_n_req
    $error("rr_dec_arbiter supports only N_REQ = 8");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_dec_arbiter MAX_HOLD must be in 2..255");
  end

  logic [1:0]         state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  id_t                gnt_id_q, gnt_id_d;
  id_t                last_ptr_q, last_ptr_d;
  logic               grant_next;

  id_t                search_start;
  id_t                rot_idx;
  id_t                winner;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot_req;
  logic               owner_req;

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Rotate so the requester just after the last winner sits at bit 0, pick the lowest set bit, rotate back.
  assign search_start = last_ptr_q + 3'd1;
  assign req_dbl      = {req, req};
  assign rot_req      = req_dbl[search_start +: N_REQ];

  always_comb begin
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) rot_idx = id_t'(i);
    end
  end

  assign winner    = search_start + rot_idx;
  assign owner_req = req[gnt_id_q];

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    last_ptr_d = last_ptr_q;
    grant_next = 1'b0;
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (en && |req) begin
          state_d    = ST_GRANT;
          gnt_id_d   = winner;
          last_ptr_d = winner;
          grant_next = 1'b1;
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ST_GRANT: begin
        // A normal release wins over the hold limit when both occur together.
        if (!owner_req) begin
          state_d = ST_GAP;
        end
`ifdef RR_DEC_ARBITER_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = ST_GAP;
          timeout_d = 1'b1;
        end else begin
          grant_next = 1'b1;
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
`else
        else begin
          grant_next = 1'b1;
        end
`endif
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  rr_onehot_dec u_dec (
    .out (gnt_d),
    .in  (gnt_id_d),
    .en  (grant_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      last_ptr_q <= RST_PTR;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      last_ptr_q <= last_ptr_d;
    end
  end

`ifdef RR_DEC_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = |gnt_q;

endmodule
